acia_host_ctrl: RTL and testbench

Bus-master controller for the ACIA serial port. Performs the ACIA init sequence after reset, polls ACIA status, drains received bytes into a one-entry holding register with a valid/ready output, and shares the transmitter between two byte requesters using round-robin arbitration. It sits between the ACIA register port (cs/we/rs/din/dout) and on-chip byte producers and consumers, so neither side handles ACIA status bits.

---
 rtl/acia_pkg.sv | 32 +++
 rtl/acia_rr2.sv | 41 ++++
 rtl/acia_host_ctrl.sv | 172 +++++++++++++++++
 tb/tb_acia_host_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acia_pkg.sv
// ---------------------------------------------------------------------------
// acia_pkg: shared FSM state, ACIA status-bit and register-select constants.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package acia_pkg;

   typedef enum logic [2:0] {
      ST_INIT_RST = 3'd0,
      ST_INIT_CFG = 3'd1,
      ST_GAP      = 3'd2,
      ST_POLL     = 3'd3,
      ST_DECIDE   = 3'd4,
      ST_RXRD     = 3'd5,
      ST_RXCAP    = 3'd6,
      ST_TXWR     = 3'd7
   } acia_state_e;

   localparam int unsigned RXF = 0;
   localparam int unsigned TXE = 1;
   localparam int unsigned FE  = 4;
   localparam int unsigned OVR = 5;

   localparam logic [7:0] ACIA_MASTER_RST = 8'h03;

   localparam logic RS_CTRL = 1'b0;
   localparam logic RS_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/acia_rr2.sv
// ---------------------------------------------------------------------------
// acia_rr2: two-way round-robin arbiter; grant index plus the `last` pointer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module acia_rr2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic       grant_o
);

   logic last_q, last_d;
   logic grant;

   always_comb begin
      grant = 1'b0;
      if (req_i == 2'b11) begin
         grant = ~last_q;
      end else if (req_i[1]) begin
         grant = 1'b1;
      end
      last_d = advance_i ? grant : last_q;
   end

   assign grant_o = grant;

   // Reset to 1 so requester 0 wins the first contested grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/acia_host_ctrl.sv
// ---------------------------------------------------------------------------
// acia_host_ctrl: ACIA bus master - init, status polling, RX holding register,
// round-robin shared TX.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module acia_host_ctrl
   import acia_pkg::*;
#(
   parameter logic [7:0]  CTRL_INIT = 8'h00,
   parameter int unsigned POLL_GAP  = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tx0_valid_i,
   input  logic [7:0] tx0_data_i,
   output logic       tx0_ready_o,
   input  logic       tx1_valid_i,
   input  logic [7:0] tx1_data_i,
   output logic       tx1_ready_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   input  logic       rx_ready_i,
   output logic       err_o,
   input  logic       err_clr_i,
   output logic       acia_cs_o,
   output logic       acia_we_o,
   output logic       acia_rs_o,
   output logic [7:0] acia_din_o,
   input  logic [7:0] acia_dout_i
);

   localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   acia_state_e   state_q, state_d;
   logic          run_q;
   logic [GW-1:0] gap_q, gap_d;
   logic          gnt_q, gnt_d;
   logic          rx_valid_q, rx_valid_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          err_q, err_d;
   logic [1:0]    arb_req;
   logic          arb_adv;
   logic          arb_grant;

   acia_rr2 u_rr2 (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (arb_req),
      .advance_i (arb_adv),
      .grant_o   (arb_grant)
   );

   // run_q holds the bus quiet until the first edge after reset release.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_q      <= 1'b0;
         state_q    <= ST_INIT_RST;
         gap_q      <= '0;
         gnt_q      <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
         err_q      <= 1'b0;
      end else begin
         run_q      <= 1'b1;
         state_q    <= state_d;
         gap_q      <= gap_d;
         gnt_q      <= gnt_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      gnt_d       = gnt_q;
      rx_valid_d  = rx_valid_q;
      rx_data_d   = rx_data_q;
      err_d       = err_q & ~err_clr_i;
      acia_cs_o   = 1'b0;
      acia_we_o   = 1'b0;
      acia_rs_o   = RS_CTRL;
      acia_din_o  = 8'h00;
      tx0_ready_o = 1'b0;
      tx1_ready_o = 1'b0;
      arb_adv     = 1'b0;
      arb_req     = {tx1_valid_i, tx0_valid_i};

      if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end

      if (run_q) begin
         case (state_q)
            ST_INIT_RST: begin
               acia_cs_o  = 1'b1;
               acia_we_o  = 1'b1;
               acia_din_o = ACIA_MASTER_RST;
               state_d    = ST_INIT_CFG;
            end
            ST_INIT_CFG: begin
               acia_cs_o  = 1'b1;
               acia_we_o  = 1'b1;
               acia_din_o = CTRL_INIT;
               gap_d      = '0;
               state_d    = ST_GAP;
            end
            ST_GAP: begin
               if (gap_q == GAP_LAST) begin
                  gap_d   = '0;
                  state_d = ST_POLL;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            ST_POLL: begin
               acia_cs_o = 1'b1;
               state_d   = ST_DECIDE;
            end
            ST_DECIDE: begin
               if (acia_dout_i[FE] || acia_dout_i[OVR]) begin
                  err_d = 1'b1;
               end
               // A full holding register leaves the byte in the ACIA.
               if (acia_dout_i[RXF] && !rx_valid_q) begin
                  state_d = ST_RXRD;
               end else if (acia_dout_i[TXE] && (tx0_valid_i || tx1_valid_i)) begin
                  gnt_d   = arb_grant;
                  state_d = ST_TXWR;
               end else begin
                  state_d = ST_GAP;
               end
            end
            ST_RXRD: begin
               acia_cs_o = 1'b1;
               acia_rs_o = RS_DATA;
               state_d   = ST_RXCAP;
            end
            ST_RXCAP: begin
               rx_data_d  = acia_dout_i;
               rx_valid_d = 1'b1;
               state_d    = ST_GAP;
            end
            ST_TXWR: begin
               acia_cs_o   = 1'b1;
               acia_we_o   = 1'b1;
               acia_rs_o   = RS_DATA;
               acia_din_o  = gnt_q ? tx1_data_i : tx0_data_i;
               tx0_ready_o = ~gnt_q;
               tx1_ready_o = gnt_q;
               // Present only the latched winner so `last` records it exactly.
               arb_req     = gnt_q ? 2'b10 : 2'b01;
               arb_adv     = 1'b1;
               state_d     = ST_GAP;
            end
            default: begin
               state_d = ST_INIT_RST;
            end
         endcase
      end
   end

   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_data_q;
   assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_acia_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acia_host_ctrl: ACIA bus model, random requesters, scoreboard monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_acia_host_ctrl;

   localparam logic [7:0] CTRL_INIT = 8'h00;
   localparam int         POLL_GAP  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx0_valid = 1'b0, tx1_valid = 1'b0;
   logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
   logic       tx0_ready, tx1_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready = 1'b0;
   logic       err;
   logic       err_clr = 1'b0;
   logic       acia_cs, acia_we, acia_rs;
   logic [7:0] acia_din;
   logic [7:0] acia_dout;

   always #5 clk = ~clk;

   acia_host_ctrl #(
      .CTRL_INIT (CTRL_INIT),
      .POLL_GAP  (POLL_GAP)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tx0_valid_i (tx0_valid),
      .tx0_data_i  (tx0_data),
      .tx0_ready_o (tx0_ready),
      .tx1_valid_i (tx1_valid),
      .tx1_data_i  (tx1_data),
      .tx1_ready_o (tx1_ready),
      .rx_valid_o  (rx_valid),
      .rx_data_o   (rx_data),
      .rx_ready_i  (rx_ready),
      .err_o       (err),
      .err_clr_i   (err_clr),
      .acia_cs_o   (acia_cs),
      .acia_we_o   (acia_we),
      .acia_rs_o   (acia_rs),
      .acia_din_o  (acia_din),
      .acia_dout_i (acia_dout)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: no matching response at %0t", name, $time);
   endtask

   // ---------------- ACIA register model ----------------
   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp0[$];
   logic [7:0] tx_exp1[$];
   logic       rxf = 1'b0, txe = 1'b1;
   logic [7:0] rx_reg = 8'h00, dout = 8'h00;
   int         txe_cnt = 0;
   bit         inject_en = 0, fe_en = 0, force_fe = 0, rnd_en = 0;

   assign acia_dout = dout;

   always @(posedge clk) begin
      logic [7:0] v;
      logic       fe_now, ovr_now;
      fe_now  = force_fe || (fe_en && ($urandom_range(0, 15) == 0));
      ovr_now = fe_en && ($urandom_range(0, 23) == 0);
      if (acia_cs && !acia_we) begin
         if (acia_rs) begin
            dout <= rx_reg;
            rxf  <= 1'b0;
         end else begin
            dout <= {2'b00, ovr_now, fe_now, 2'b00, txe, rxf};
         end
      end
      if (acia_cs && acia_we && acia_rs) begin
         txe     <= 1'b0;
         txe_cnt <= $urandom_range(1, 8);
      end else if (!txe) begin
         if (txe_cnt <= 1) txe <= 1'b1;
         else txe_cnt <= txe_cnt - 1;
      end
      if (inject_en && !rxf && ($urandom_range(0, 3) == 0)) begin
         v = 8'($urandom);
         rx_reg <= v;
         rxf    <= 1'b1;
         rx_exp.push_back(v);
      end
   end

   // ---------------- scoreboard monitor ----------------
   bit mon_en = 0;
   int cyc = 0;
   bit prev_poll = 0;
   int exp_act = -1;
   bit exp_g = 0;
   int next_poll = -1;
   bit m_last = 1;
   bit m_err = 0;

   always @(negedge clk) begin
      logic       poll_now;
      logic [7:0] st;
      if (mon_en) begin
         cyc++;
         poll_now = acia_cs && !acia_we && !acia_rs;
         st       = acia_dout;
         if (!acia_we) chk("din_zero_on_read", {24'd0, acia_din}, 32'd0);
         chk("err_flag", {31'd0, err}, {31'd0, m_err});
         if (exp_act == 0) begin
            chk("idle_after_decide", {31'd0, acia_cs}, 32'd0);
         end else if (exp_act == 1) begin
            chk("rx_data_read", {29'd0, acia_cs, acia_we, acia_rs}, 32'b101);
         end else if (exp_act == 2) begin
            chk("tx_write_strobe", {29'd0, acia_cs, acia_we, acia_rs}, 32'b111);
            chk("tx_grant", {30'd0, tx1_ready, tx0_ready}, exp_g ? 32'b10 : 32'b01);
            if (exp_g) begin
               if (tx_exp1.size() == 0) fail("tx1_unexpected_write");
               else chk("tx1_data", {24'd0, acia_din}, {24'd0, tx_exp1.pop_front()});
            end else begin
               if (tx_exp0.size() == 0) fail("tx0_unexpected_write");
               else chk("tx0_data", {24'd0, acia_din}, {24'd0, tx_exp0.pop_front()});
            end
            m_last = exp_g;
         end
         if (exp_act != 2) chk("stray_ready", {30'd0, tx1_ready, tx0_ready}, 32'd0);
         exp_act = -1;
         if (poll_now && next_poll >= 0) chk("poll_time", cyc, next_poll);
         if (prev_poll) begin
            if (st[0] && !rx_valid) begin
               exp_act   = 1;
               next_poll = cyc + POLL_GAP + 3;
            end else if (st[1] && (tx0_valid || tx1_valid)) begin
               exp_act   = 2;
               exp_g     = (tx0_valid && tx1_valid) ? ~m_last : tx1_valid;
               next_poll = cyc + POLL_GAP + 2;
            end else begin
               exp_act   = 0;
               next_poll = cyc + POLL_GAP + 1;
            end
         end
         if (prev_poll && (st[4] || st[5])) m_err = 1;
         else if (err_clr) m_err = 0;
         if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) fail("rx_unexpected_byte");
            else chk("rx_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
         end
         prev_poll = poll_now;
      end
   end

   // ---------------- stimulus ----------------
   task automatic check_init();
      int c;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("init0_strobe", {29'd0, acia_cs, acia_we, acia_rs}, 32'b110);
      chk("init0_din", {24'd0, acia_din}, 32'h03);
      @(negedge clk);
      chk("init1_strobe", {29'd0, acia_cs, acia_we, acia_rs}, 32'b110);
      chk("init1_din", {24'd0, acia_din}, {24'd0, CTRL_INIT});
      c = 1;
      do begin
         @(negedge clk);
         c++;
         if (!(acia_cs && !acia_we && !acia_rs)) chk("gap_quiet", {31'd0, acia_cs}, 32'd0);
      end while (!(acia_cs && !acia_we && !acia_rs) && c < 40);
      chk("first_poll_cycle", c, 2 + POLL_GAP);
      #1;
      cyc       = c;
      prev_poll = 1;
      next_poll = -1;
      exp_act   = -1;
      m_err     = 0;
      m_last    = 1;
      mon_en    = 1;
   endtask

   task automatic check_all_zero(input string name);
      chk(name, {17'd0, acia_cs, acia_we, acia_rs, acia_din, tx0_ready, tx1_ready, rx_valid, err},
          32'd0);
   endtask

   task automatic req_run(input int r, input int n);
      logic [7:0] d;
      int         w;
      bit         ok;
      for (int i = 0; i < n; i++) begin
         w = $urandom_range(0, 3);
         repeat (w) @(posedge clk);
         #1;
         d = 8'($urandom);
         if (r == 0) begin
            tx0_valid = 1'b1; tx0_data = d; tx_exp0.push_back(d);
         end else begin
            tx1_valid = 1'b1; tx1_data = d; tx_exp1.push_back(d);
         end
         ok = 0;
         for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if ((r == 0) ? tx0_ready : tx1_ready) begin
               ok = 1;
               break;
            end
         end
         if (!ok) fail("tx_ready_timeout");
         @(posedge clk);
         #1;
         if (r == 0) tx0_valid = 1'b0;
         else tx1_valid = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
         rx_ready = ($urandom_range(0, 2) == 0);
         err_clr  = ($urandom_range(0, 7) == 0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");
      check_init();

      inject_en = 1;
      fe_en     = 1;
      rnd_en    = 1;
      fork
         req_run(0, 40);
         req_run(1, 40);
      join
      @(posedge clk);
      #1;
      inject_en = 0;
      fe_en     = 0;
      rnd_en    = 0;
      rx_ready  = 1'b1;
      err_clr   = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      err_clr  = 1'b1;
      force_fe = 1;
      repeat (25) @(posedge clk);
      #1;
      force_fe = 0;
      repeat (15) @(posedge clk);
      #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("rx_queue_drained", rx_exp.size(), 0);
      chk("tx0_queue_drained", tx_exp0.size(), 0);
      chk("tx1_queue_drained", tx_exp1.size(), 0);

      // Reset asserted in the middle of a TX write.
      #1;
      mon_en = 0;
      @(posedge clk);
      #1;
      tx0_valid = 1'b1;
      tx0_data  = 8'h41;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (acia_cs && acia_we && acia_rs) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail("txwr_before_reset_timeout");
      chk("txwr_din_before_reset", {24'd0, acia_din}, 32'h41);
      chk("txwr_ready_before_reset", {31'd0, tx0_ready}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset_outputs");
      tx0_valid = 1'b0;
      @(negedge clk);
      check_all_zero("held_reset_outputs");
      check_init();
      repeat (20) @(negedge clk);
      #1;
      mon_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
